// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
//   Bundles the producer handshake, the pause control and the serial output
//   of word_serializer so that both ends can be connected as a single port.
//
//   Signals
//     in_data    [WIDTH-1:0]  parallel word from the producer
//     in_valid                in_data is valid
//     in_ready                serializer can accept a word (registered)
//     pause                   stall bit emission for the next cycle
//     data                    serial bit to the downstream detector (registered)
//     data_valid              data carries a real bit this cycle (registered)
//     busy                    a word is stored or bits are still pending
//
//   Modports
//     master  the producer/consumer side that drives in_data/in_valid/pause
//     slave   the serializer itself
// -----------------------------------------------------------------------------
interface word_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             pause;
  logic             data;
  logic             data_valid;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    output pause,
    input  in_ready,
    input  data,
    input  data_valid,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  pause,
    output in_ready,
    output data,
    output data_valid,
    output busy
  );

endinterface : word_serializer_if

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Accepts WIDTH-bit words through a valid/ready handshake, buffers up to two
//   of them in a small FIFO and sends them out one bit per cycle, back to back,
//   either MSB-first or LSB-first. A pause input stalls emission without losing
//   or reordering any bit.
//
//   Parameters
//     WIDTH      word width in bits, 2..32
//     MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; empties the FIFO, drops any
//            partly sent word and clears all outputs
//     bus    word_serializer_if.slave (in_data/in_valid/in_ready, pause,
//            data/data_valid, busy)
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  word_serializer_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_IDX = cnt_t'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  word_t      fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  word_t      shifter;
  cnt_t       remaining;

  logic       in_ready_q;
  logic       data_q;
  logic       data_valid_q;
  logic       busy_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       push;
  logic       pop;
  logic       emit;
  logic [1:0] count_next;
  cnt_t       remaining_next;
  word_t      head;
  logic       head_first_bit;
  word_t      head_rest;
  logic       shifter_bit;
  word_t      shifter_advanced;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    push             = 1'b0;
    pop              = 1'b0;
    emit             = 1'b0;
    count_next       = count;
    remaining_next   = remaining;
    head             = fifo_mem[rd_ptr];
    head_first_bit   = 1'b0;
    head_rest        = '0;
    shifter_bit      = 1'b0;
    shifter_advanced = '0;

    // in_ready already reflects count < 2 after the previous edge, so a full
    // FIFO is never written even when a pop happens on the same edge.
    push = bus.in_valid && in_ready_q && (count != 2'd2);

    emit = !bus.pause && ((remaining != '0) || (count != 2'd0));
    pop  = emit && (remaining == '0);

    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase

    if (emit) begin
      remaining_next = (remaining == '0) ? LAST_IDX : remaining - cnt_t'(1);
    end

    // The bit on its way out always sits at the "exit" end of the shifter;
    // the load path drops the head's first bit straight onto data and keeps
    // the rest aligned to that same exit end.
    if (MSB_FIRST) begin
      head_first_bit   = head[WIDTH-1];
      head_rest        = head << 1;
      shifter_bit      = shifter[WIDTH-1];
      shifter_advanced = shifter << 1;
    end else begin
      head_first_bit   = head[0];
      head_rest        = head >> 1;
      shifter_bit      = shifter[0];
      shifter_advanced = shifter >> 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values computed above, independent of
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      remaining    <= '0;
      in_ready_q   <= 1'b0;
      data_q       <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count        <= count_next;
      remaining    <= remaining_next;
      in_ready_q   <= (count_next < 2'd2);
      busy_q       <= (count_next != 2'd0) || (remaining_next != '0);
      data_valid_q <= emit;
      if (emit) data_q <= pop ? head_first_bit : shifter_bit;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath storage
  // ---------------------------------------------------------------------------
  // NOTE: the FIFO entries and the shifter carry no reset; their contents are
  // only ever read while count/remaining mark them as holding live data, and
  // those qualifiers are reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.in_data;
    if (emit) shifter <= pop ? head_rest : shifter_advanced;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;

endmodule : word_serializer

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  parallel word from the producer.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block can accept a word; registered.
REQ-008 pause  input  1  stalls bit emission; the block SHALL emit no bit in the next cycle.
REQ-009 data  output  1  serial bit to the downstream sequence detector; registered.
REQ-010 data_valid  output  1  data carries a real bit this cycle; registered.
REQ-011 busy  output  1  a word is stored or bits are still pending; registered.

Function
REQ-012 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; otherwise in_data SHALL be ignored.
REQ-013 Accepted words SHALL enter a 2-entry FIFO in arrival order; no word SHALL be dropped or duplicated.
REQ-014 A shift register with a remaining-bit counter (0..WIDTH-1) SHALL hold the word currently being sent.
REQ-015 Emit condition per edge: pause=0 AND (remaining>0 OR FIFO non-empty).
REQ-016 On emit with remaining>0: data SHALL take the next bit of the shifter, the shifter SHALL advance, and remaining SHALL be decremented.
REQ-017 On emit with remaining=0: the FIFO head SHALL be popped; its first bit SHALL drive data; the other WIDTH-1 bits SHALL load into the shifter; remaining SHALL be set to WIDTH-1.
REQ-018 On an edge where the block emits, data_valid SHALL be 1; on any other edge, data_valid SHALL be 0 and data SHALL hold its previous value.
REQ-019 Latency: a word accepted at edge E0 into an empty, idle block with pause=0 SHALL show its first bit after edge E1; its last bit SHALL show after edge E0+WIDTH.
REQ-020 Consecutive words SHALL be sent with no gap: the last bit of word K and the first bit of word K+1 SHALL appear in adjacent cycles when pause=0 and word K+1 is stored.
REQ-021 Pause SHALL freeze the shifter, remaining and the FIFO pop; the bit order after pause is released SHALL match the unpaused order.
REQ-022 A push and a pop on the same edge SHALL leave the FIFO count unchanged and keep the order.
REQ-023 in_ready next-state SHALL be (FIFO count after this edge) < 2.
REQ-024 A word SHALL never be accepted into a full FIFO, even if a pop happens on the same edge.
REQ-025 busy next-state SHALL be (FIFO count after this edge > 0) OR (remaining after this edge > 0).
REQ-026 Sustained throughput SHALL be one word per WIDTH cycles.

Reset
REQ-027 While rst_n=0, outputs SHALL be forced to: data=0, data_valid=0, in_ready=0, busy=0.
REQ-028 While rst_n=0, the FIFO SHALL be emptied and remaining SHALL be 0.
REQ-029 in_ready SHALL first read 1 after the first rising edge following rst_n deassertion.
REQ-030 Reset asserted mid-word SHALL discard all stored and partly sent bits; no residual bit SHALL be emitted after release.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, push 8'h36, pause=0 -> data_valid high for 8 consecutive cycles with data 0,0,1,1,0,1,1,0; busy falls the cycle after the last bit.
REQ-032 MSB_FIRST=1, push 8'h36 then 8'hA5 back-to-back -> 16 contiguous valid bits 00110110 10100101; in_ready never falls.
REQ-033 pause=1 for 3 cycles after the 3rd bit of 8'h36 -> data_valid=0 for exactly 3 cycles, then the remaining bits 10110 with no gap.
REQ-034 pause held at 1, push 8'h01, 8'h02, 8'h03 -> the first two are accepted, in_ready=0 and the third is held. On pause release -> 24 bits in order 01, 02, 03; the third word is accepted once a pop frees an entry.
REQ-035 rst_n pulsed low during the 4th bit of 8'hFF -> data_valid and busy go 0 at once; no further bits after release; in_ready returns to 1 one edge later.
REQ-036 MSB_FIRST=0, push 8'h36 -> bits 0,1,1,0,1,1,0,0.
